// File: rtl/uart_bridge_pkg.sv
// Shared constants and state encodings for the UART-driven bus initiator.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RPL_OK    = 8'h4B;
  localparam logic [7:0] RPL_ERR   = 8'h45;

  localparam int DEFAULT_BAUD_DIV      = 651;
  localparam int DEFAULT_TIMEOUT_TICKS = 640;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } cmd_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Peripheral bus seen by the bridge: single-cycle rd/wr strobes plus the busy flag used by the top-level mux.
interface uart_bus_bridge_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;

  modport master (output rd, wr, addr, wdata, busy, input rdata);
  modport slave  (input rd, wr, addr, wdata, busy, output rdata);
endinterface

// File: rtl/uart_rx_core.sv
// 16x oversampled 8N1 receiver with a 2-flop input synchronizer; emits byte-valid or framing-error pulses.
module uart_rx_core
  import uart_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  rx_state_e  state;
  logic       rxd_m;
  logic       rxd_s;
  logic [3:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk) begin
    rx_valid <= 1'b0;
    rx_ferr  <= 1'b0;
    if (reset) begin
      state <= RX_IDLE;
      tcnt  <= 4'd0;
      bcnt  <= 3'd0;
    end else if (tick) begin
      case (state)
        RX_IDLE: begin
          if (!rxd_s) begin
            state <= RX_START;
            tcnt  <= 4'd0;
          end
        end
        // Re-check at mid start bit so short glitches are rejected.
        RX_START: begin
          if (tcnt == 4'd7) begin
            tcnt  <= 4'd0;
            bcnt  <= 3'd0;
            state <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        RX_DATA: begin
          if (tcnt == 4'd15) begin
            tcnt  <= 4'd0;
            shreg <= {rxd_s, shreg[7:1]};
            bcnt  <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= RX_STOP;
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        RX_STOP: begin
          if (tcnt == 4'd15) begin
            tcnt <= 4'd0;
            if (rxd_s) begin
              rx_valid <= 1'b1;
              state    <= RX_IDLE;
            end else begin
              rx_ferr <= 1'b1;
              state   <= RX_BREAK;
            end
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        // A low stop bit means the line may still be held low; wait for idle before hunting again.
        RX_BREAK: begin
          if (rxd_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command decoder acting as a second bus master: 'W' writes, 'R' reads, anything else answers 'E'.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int BAUD_DIV      = DEFAULT_BAUD_DIV,
  parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  output logic              txd,
  uart_bus_bridge_if.master bus
);

  localparam int TICK_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TMO_W  = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  logic [TICK_W-1:0] div_cnt;
  logic              tick;
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_ferr;

  cmd_state_e        state;
  logic [7:0]        cmd_byte;
  logic              is_write;
  logic [1:0]        byte_idx;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              rd_r;
  logic              wr_r;
  logic              busy_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic              txd_r;
  logic [31:0]       resp_word;
  logic [2:0]        resp_left;
  logic              tx_on;
  logic [3:0]        tx_bit;
  logic [3:0]        tx_tcnt;
  logic [7:0]        tx_shift;

  assign tick = (div_cnt == TICK_W'(BAUD_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + TICK_W'(1);
  end

  uart_rx_core u_rx (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .rxd      (rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      is_write  <= 1'b0;
      byte_idx  <= 2'd0;
      tmo_cnt   <= '0;
      rd_r      <= 1'b0;
      wr_r      <= 1'b0;
      busy_r    <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      txd_r     <= 1'b1;
      resp_left <= 3'd0;
      tx_on     <= 1'b0;
      tx_bit    <= 4'd0;
      tx_tcnt   <= 4'd0;
    end else begin
      rd_r <= 1'b0;
      wr_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            cmd_byte <= rx_byte;
            busy_r   <= 1'b1;
            state    <= ST_CMD;
          end
        end
        ST_CMD: begin
          byte_idx <= 2'd0;
          tmo_cnt  <= '0;
          tx_on    <= 1'b0;
          if (cmd_byte == CMD_WRITE || cmd_byte == CMD_READ) begin
            is_write <= (cmd_byte == CMD_WRITE);
            state    <= ST_ADDR;
          end else begin
            resp_word <= {RPL_ERR, 24'h0};
            resp_left <= 3'd1;
            state     <= ST_RESP;
          end
        end
        // Argument bytes arrive MSB first and shift into addr/wdata in place.
        ST_ADDR, ST_DATA: begin
          if (rx_ferr) begin
            busy_r <= 1'b0;
            state  <= ST_IDLE;
          end else if (rx_valid) begin
            tmo_cnt  <= '0;
            byte_idx <= byte_idx + 2'd1;
            if (state == ST_ADDR) addr_r  <= {addr_r[23:0], rx_byte};
            else                  wdata_r <= {wdata_r[23:0], rx_byte};
            if (byte_idx == 2'd3) begin
              if (state == ST_ADDR && is_write) begin
                state <= ST_DATA;
              end else begin
                wr_r  <= is_write;
                rd_r  <= !is_write;
                state <= ST_BUS;
              end
            end
          end else if (tick) begin
            if (tmo_cnt == TMO_W'(TIMEOUT_TICKS - 1)) begin
              busy_r <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
        end
        ST_BUS: begin
          if (is_write) begin
            resp_word <= {RPL_OK, 24'h0};
            resp_left <= 3'd1;
          end else begin
            resp_word <= bus.rdata;
            resp_left <= 3'd4;
          end
          state <= ST_RESP;
        end
        // Transmitter: tx_bit 0 = start, 1..8 = data LSB first, 9 = stop; 16 ticks each.
        ST_RESP: begin
          if (tick) begin
            if (!tx_on) begin
              tx_on    <= 1'b1;
              txd_r    <= 1'b0;
              tx_bit   <= 4'd0;
              tx_tcnt  <= 4'd0;
              tx_shift <= resp_word[31:24];
            end else if (tx_tcnt != 4'd15) begin
              tx_tcnt <= tx_tcnt + 4'd1;
            end else begin
              tx_tcnt <= 4'd0;
              if (tx_bit == 4'd9) begin
                if (resp_left == 3'd1) begin
                  tx_on  <= 1'b0;
                  busy_r <= 1'b0;
                  state  <= ST_IDLE;
                end else begin
                  resp_left <= resp_left - 3'd1;
                  resp_word <= {resp_word[23:0], 8'h00};
                  tx_shift  <= resp_word[23:16];
                  txd_r     <= 1'b0;
                  tx_bit    <= 4'd0;
                end
              end else if (tx_bit == 4'd8) begin
                txd_r  <= 1'b1;
                tx_bit <= 4'd9;
              end else begin
                txd_r    <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 4'd1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign txd       = txd_r;
  assign bus.rd    = rd_r;
  assign bus.wr    = wr_r;
  assign bus.addr  = addr_r;
  assign bus.wdata = wdata_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: commands are decoded by a byte-level model, bus and serial monitors check the DUT.
module tb_uart_bus_bridge;

  localparam int BAUD_DIV = 2;
  localparam int TMO      = 640;
  localparam int BIT      = 16 * BAUD_DIV;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_op_t;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        rxd;
  logic        txd;
  logic [31:0] rdata_val;

  int          n_vec = 0;
  int          n_err = 0;
  bus_op_t     exp_bus[$];
  logic [7:0]  exp_tx[$];

  uart_bus_bridge_if bus_if ();

  assign bus_if.rdata = bus_if.rd ? rdata_val : 32'hDEAD_BEEF;

  uart_bus_bridge #(.BAUD_DIV(BAUD_DIV), .TIMEOUT_TICKS(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .txd   (txd),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Reference model: what a command byte sequence must produce on the bus and the serial reply.
  task automatic model(input byte_q_t cmd, input logic [31:0] rdv);
    bus_op_t op;
    if (cmd[0] == 8'h57) begin
      op.is_wr = 1'b1;
      op.addr  = {cmd[1], cmd[2], cmd[3], cmd[4]};
      op.wdata = {cmd[5], cmd[6], cmd[7], cmd[8]};
      exp_bus.push_back(op);
      exp_tx.push_back(8'h4B);
    end else if (cmd[0] == 8'h52) begin
      op.is_wr = 1'b0;
      op.addr  = {cmd[1], cmd[2], cmd[3], cmd[4]};
      op.wdata = '0;
      exp_bus.push_back(op);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(rdv[i*8 +: 8]);
    end else begin
      exp_tx.push_back(8'h45);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_bytes(input byte_q_t cmd);
    foreach (cmd[i]) begin
      send_byte(cmd[i], 1'b1);
      if (i == 0) check("busy_rise", {31'b0, bus_if.busy}, 32'd1);
      repeat ($urandom_range(0, BIT)) @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus_if.busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall_in_time", {31'b0, (n < budget)}, 32'd1);
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic run_cmd(input byte_q_t cmd, input logic [31:0] rdv);
    rdata_val = rdv;
    model(cmd, rdv);
    send_bytes(cmd);
    wait_idle(60 * BIT);
  endtask

  function automatic byte_q_t mk_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
    byte_q_t q;
    q.push_back(c);
    if (c == 8'h57 || c == 8'h52)
      for (int i = 3; i >= 0; i--) q.push_back(a[i*8 +: 8]);
    if (c == 8'h57)
      for (int i = 3; i >= 0; i--) q.push_back(d[i*8 +: 8]);
    return q;
  endfunction

  // Bus monitor.
  initial begin
    bus_op_t e;
    forever begin
      @(negedge clk);
      if (bus_if.rd === 1'b1 || bus_if.wr === 1'b1) begin
        if (exp_bus.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL bus_unexpected: rd=%b wr=%b addr=%h, required no access",
                   bus_if.rd, bus_if.wr, bus_if.addr);
        end else begin
          e = exp_bus.pop_front();
          check("bus_kind", {30'b0, bus_if.wr, bus_if.rd}, e.is_wr ? 32'd2 : 32'd1);
          check("bus_addr", bus_if.addr, e.addr);
          if (e.is_wr) check("bus_wdata", bus_if.wdata, e.wdata);
        end
      end
    end
  end

  // Serial reply monitor; frames cut short by reset are dropped.
  initial begin
    logic [7:0] got;
    logic       stop;
    bit         abort;
    forever begin
      @(negedge clk);
      if (txd === 1'b0 && reset === 1'b0) begin
        abort = 1'b0;
        repeat (BIT / 2) begin
          @(negedge clk);
          if (reset) abort = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) begin
            @(negedge clk);
            if (reset) abort = 1'b1;
          end
          got[i] = txd;
        end
        repeat (BIT) begin
          @(negedge clk);
          if (reset) abort = 1'b1;
        end
        stop = txd;
        if (!abort) begin
          if (exp_tx.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_unexpected: got byte %h, required no reply", got);
          end else begin
            check("tx_byte", {23'b0, stop, got}, {23'b0, 1'b1, exp_tx.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    byte_q_t     q;
    logic [7:0]  c;
    logic [31:0] a;
    logic [31:0] d;

    reset     = 1'b1;
    rxd       = 1'b1;
    rdata_val = '0;
    repeat (5) @(negedge clk);
    check("rst_txd",   {31'b0, txd},         32'd1);
    check("rst_busy",  {31'b0, bus_if.busy}, 32'd0);
    check("rst_rd",    {31'b0, bus_if.rd},   32'd0);
    check("rst_wr",    {31'b0, bus_if.wr},   32'd0);
    check("rst_addr",  bus_if.addr,          32'd0);
    check("rst_wdata", bus_if.wdata,         32'd0);
    reset = 1'b0;
    repeat (2 * BIT) @(negedge clk);

    run_cmd(mk_cmd(8'h57, 32'h4000_000C, 32'h0000_00A5), '0);
    run_cmd(mk_cmd(8'h52, 32'h4000_0010, '0), 32'h0000_003C);
    run_cmd(mk_cmd(8'h33, '0, '0), '0);

    // Framing error on the first address byte aborts silently.
    send_byte(8'h57, 1'b1);
    send_byte(8'h40, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    check("ferr_busy", {31'b0, bus_if.busy}, 32'd0);
    run_cmd(mk_cmd(8'h52, 32'h4000_0004, '0), 32'h1234_5678);

    // Stall mid-address: still busy before the timeout, idle after it.
    send_byte(8'h52, 1'b1);
    send_byte(8'h40, 1'b1);
    repeat (500 * BAUD_DIV) @(negedge clk);
    check("tmo_busy_hold", {31'b0, bus_if.busy}, 32'd1);
    repeat (250 * BAUD_DIV) @(negedge clk);
    check("tmo_busy_drop", {31'b0, bus_if.busy}, 32'd0);
    run_cmd(mk_cmd(8'h52, 32'h4000_0020, '0), 32'hCAFE_F00D);

    // Glitch shorter than half a bit must not produce a byte.
    @(negedge clk);
    rxd = 1'b0;
    repeat (4 * BAUD_DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (20 * BIT) @(negedge clk);
    check("false_start_busy", {31'b0, bus_if.busy}, 32'd0);

    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 2))
        0:       c = 8'h57;
        1:       c = 8'h52;
        default: begin
          c = 8'($urandom_range(0, 255));
          if (c == 8'h57 || c == 8'h52) c = 8'h00;
        end
      endcase
      a = $urandom();
      d = $urandom();
      run_cmd(mk_cmd(c, a, d), $urandom());
    end

    // Reset in the middle of the second reply byte.
    q = mk_cmd(8'h52, 32'h4000_0030, '0);
    rdata_val = 32'hA1B2_C3D4;
    model(q, rdata_val);
    send_bytes(q);
    repeat (14 * BIT) @(negedge clk);
    check("resp_bytes_left", exp_tx.size(), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_txd",   {31'b0, txd},         32'd1);
    check("midrst_busy",  {31'b0, bus_if.busy}, 32'd0);
    check("midrst_rd",    {31'b0, bus_if.rd},   32'd0);
    check("midrst_wr",    {31'b0, bus_if.wr},   32'd0);
    check("midrst_addr",  bus_if.addr,          32'd0);
    check("midrst_wdata", bus_if.wdata,         32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_tx.delete();
    repeat (12 * BIT) @(negedge clk);
    check("post_rst_txd", {31'b0, txd}, 32'd1);

    check("exp_bus_left", exp_bus.size(), 32'd0);
    check("exp_tx_left",  exp_tx.size(),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

UART-driven bus initiator: receives command frames on a serial line and issues single read/write transactions on the peripheral bus (rd/wr/addr/wdata/rdata), returning results over a serial transmit line. It is the host-side counterpart of the memory-mapped peripheral. A PC can load, poke, and inspect TH/TL/TCON/led/digi/UART registers and memory without CPU involvement. It sits beside the CPU as a second bus master; the top level muxes it in while `busy` is high.

## Interface
- BAUD_DIV, 651: clk cycles per oversample tick (16 ticks per bit; 100 MHz, 9600 baud).
- TIMEOUT_TICKS, 640: oversample ticks allowed between bytes of one command before abort.
- clk  in  1  system clock.
- reset  in  1  reset; one clock, reset is synchronous and active-high.
- rxd  in  1  serial input, idle high, asynchronous to clk.
- txd  out  1  serial output, idle high.
- rd  out  1  bus read strobe, one-cycle pulse.
- wr  out  1  bus write strobe, one-cycle pulse.
- addr  out  32  bus address.
- wdata  out  32  bus write data.
- rdata  in  32  bus read data, combinational from slave, valid in the cycle rd is high.
- busy  out  1  high from first command byte accepted until response stop bit finishes.

## Operation
- Frame: 8N1, LSB first. Commands are MSB-first byte sequences:
  - 0x57 'W' + 4 addr bytes + 4 data bytes → one write, reply 0x4B 'K'.
  - 0x52 'R' + 4 addr bytes → one read, reply 4 bytes of rdata MSB first.
  - Any other first byte → reply 0x45 'E', no bus access.
- Receiver: rxd through 2-flop synchronizer. In idle, low level starts tick count; at tick 8 rxd still low confirms start, else false start, back to idle. Data bits sampled at tick 8 of each bit period; stop bit sampled at tick 8 of bit 9. Stop = 1 → one-cycle byte-valid pulse. Stop = 0 → framing error: byte dropped, command FSM returns to IDLE, no reply.
- Command FSM states: IDLE → CMD decode → ADDR (count 0..3) → DATA (0..3, W only) → BUS → RESP → IDLE.
- BUS: exactly one cycle with wr=1 (W) or rd=1 (R); rdata captured into 32-bit response register in that cycle.
- RESP: transmitter sends 1 or 4 bytes back-to-back: start bit 16 ticks, 8 data bits, stop bit 16 ticks.
- Bytes received during BUS/RESP are discarded; receiver stays running.
- Timeout: in ADDR/DATA, if TIMEOUT_TICKS ticks pass with no byte-valid, return to IDLE, no reply, no bus access.
- addr/wdata hold their last values until overwritten by the next command's bytes. addr loads by shifting left 8 with each byte.

## Timing
- Reset values: txd=1, rd=0, wr=0, addr=0, wdata=0, busy=0; all FSMs idle, tick counters 0.
- Reset mid-frame or mid-response: aborts immediately; txd=1 next cycle; no partial bus access.
- The tick generator is a free-running counter 0..BAUD_DIV-1 and is cleared by reset.
- Last command byte-valid at cycle N → BUS at N+1 (rd/wr high only in N+1) → txd start bit begins on first tick at or after N+2.
- busy rises the cycle after the command byte-valid. It falls the cycle after the final stop bit's 16th tick. For 'E' replies, busy spans only the reply byte.
- Back-to-back commands: a start bit arriving during RESP is ignored. The next command must begin after busy falls.
- One bus transaction per command; rd and wr are never high together.

## Structure
- Package uart_bridge_pkg: command/reply byte constants (0x57, 0x52, 0x4B, 0x45), command FSM state enum, default BAUD_DIV.
- Sub-module uart_rx_core: synchronizer, oversampled receiver, byte/valid/framing-error outputs.
- Transmitter, tick generator and command FSM stay in the top module.

## Test plan
- Send 57 40 00 00 0C 00 00 00 A5 → wr pulses once with addr=0x4000000C, wdata=0x000000A5; txd returns 0x4B; busy low afterward.
- Send 52 40 00 00 10 with rdata=0x0000003C during rd → rd pulses once with addr=0x40000010; txd returns 00 00 00 3C in order.
- Send 0x33 → no rd/wr; txd returns 0x45.
- Send 57 followed by a byte with stop bit 0 → no wr, no reply, FSM idle. A following valid 'R' command is processed normally.
- Send 52 40 then silence > 640 ticks → no rd, no reply. Then a full 'R' command → correct 4-byte reply.
- Assert reset during the 2nd reply byte → txd=1 next cycle, busy=0, rd=wr=0, addr=wdata=0.
- Pulse rxd low for 4 ticks only → false start rejected, no byte-valid.
